uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Parametrised oversampling UART receiver: programmable baud divisor, 5-9 data bits, none/even/odd parity, 1 or 2 stop bits.
//  Mid-bit sampling, false-start rejection, per-word parity/framing status, FWFT receive FIFO with sticky overrun.
//  Sits between the async serial pin and the register/bus layer; successor to the fixed 8-bit receiver.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, 5..9, LSB first
//  OVERSAMPLE  16  oversample ticks per bit, even, >=8
//  FIFO_DEPTH  8   receive FIFO words, power of 2, >=2
// PORTS
//  rx_clk       in   1            system clock, all logic on posedge
//  rst_n        in   1            asynchronous, active-low reset
//  serial_in    in   1            async serial line, idle high
//  baud_div     in   16           oversample tick period = baud_div+1 rx_clk cycles; change only while busy=0
//  parity_mode  in   2            00 none, 01 even, 10 odd, 11 treated as none
//  two_stop     in   1            1: two stop bits expected
//  rx_ready     in   1            consumer accepts head word
//  rx_valid     out  1            FIFO not empty
//  rx_data      out  DATA_BITS    head word data
//  parity_err   out  1            head word parity error
//  frame_err    out  1            head word framing error (stop sampled 0)
//  overrun      out  1            sticky: word dropped on full FIFO
//  overrun_clr  in   1            clears overrun
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  words held
//  busy         out  1            FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0; synchroniser flops 1; FSM IDLE; tick/sample/bit counters 0; FIFO empty.
//  serial_in through 2-flop synchroniser; falling edge = prev 1, cur 0 on synchronised line.
//  Tick counter counts 0..baud_div, pulses tick and wraps at baud_div; free-running, reloaded to 0 on start edge.
//  FSM IDLE->START on falling edge. START: at tick OVERSAMPLE/2-1 sample; 1 -> IDLE (false start), 0 -> DATA, sample cnt 0.
//  DATA: sample every OVERSAMPLE ticks, shift LSB first; after DATA_BITS -> PARITY if mode 01/10, else STOP.
//  PARITY: err = ^{data,bit} for even, ~^{data,bit} for odd; 0 when parity disabled.
//  STOP: sample; 0 sets frame_err. two_stop=1 -> STOP2, sampled same way, either 0 sets frame_err.
//  At last stop sample push {frame_err,parity_err,data} to FIFO, go IDLE same cycle (mid-stop resync allowed).
//  Frame-error words are pushed, not discarded; IDLE waits for line high->low before next frame.
//  FIFO FWFT: rx_data/flags show head; rx_valid 1 rx_clk after push into empty FIFO; pop on rx_valid&rx_ready.
//  Push when full and no pop: word dropped, overrun<=1. Push+pop same cycle when full: both accepted, no overrun.
//  overrun_clr and new overrun same cycle: set wins. Pointers wrap modulo FIFO_DEPTH.
//  rst_n low mid-frame: immediate abort, FIFO flushed, no partial word pushed.
//  parity_mode/two_stop latched at START entry; changes mid-frame take effect next frame.
// CONFIGURATION
//  UART_RX_MAJORITY_VOTE_EN defined: each bit (start, data, parity, stop) = majority of samples at ticks mid-1, mid, mid+1.
//  Not defined: single sample at tick mid (OVERSAMPLE/2-1). Frame timing identical either way.
// STRUCTURE
//  Package uart_pkg: FSM state enum (IDLE,START,DATA,PARITY,STOP,STOP2), parity mode constants, status word field offsets.
//  Sub-module uart_rx_fifo: parametrised FWFT FIFO (width DATA_BITS+2, depth FIFO_DEPTH), count, full/empty.
//  Top holds synchroniser, tick generator, FSM, shift register, parity calc, overrun flag.
// TESTING (baud_div=3 -> 4 clk/tick, 64 clk/bit, OVERSAMPLE=16)
//  8N1 frame 0xA5 -> rx_valid with rx_data=0xA5, parity_err=0, frame_err=0, fifo_count=1.
//  8E1 0x03 with parity bit 1 -> parity_err=1; 7O2 0x41 correct parity -> no errors, data=0x41.
//  Stop bit driven 0 on 0x55 -> word pushed, frame_err=1; next valid frame received correctly.
//  24-clk low glitch on idle line -> no push, busy returns 0 within 1 bit time.
//  FIFO_DEPTH+1 frames, rx_ready=0 -> fifo_count=FIFO_DEPTH, overrun=1, first word intact; overrun_clr -> 0.
//  rst_n low during DATA of 2nd frame -> outputs 0, FIFO empty; following frame 0x3C received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   rx_state_e        receiver FSM states
//   PARITY_*          parity_mode encodings (2'b11 behaves as none)
//   status word       {frame_err, parity_err, data[DATA_BITS-1:0]} as stored in the FIFO
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } rx_state_e;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    // Status word field offsets
    localparam int unsigned STATUS_DATA_LSB = 0;

    function automatic int unsigned status_par_pos(input int unsigned data_bits);
        return data_bits;
    endfunction

    function automatic int unsigned status_frm_pos(input int unsigned data_bits);
        return data_bits + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received status words.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en/wr_data  push request and word
//   rd_en        pop request (ignored when empty)
//   rd_data      head word, forced to 0 while empty
//   full, empty, count  occupancy
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with programmable baud divisor, 5..9 data bits,
// none/even/odd parity, 1 or 2 stop bits, and a FWFT receive FIFO.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN -- each bit is the majority of
// the samples at ticks mid-1, mid and mid+1 instead of a single mid-bit sample.
// Ports:
//   rx_clk, rst_n          clock, asynchronous active-low reset
//   serial_in              async serial line, idle high
//   baud_div               oversample tick period = baud_div+1 clocks
//   parity_mode, two_stop  frame format, latched at start-bit detection
//   rx_ready/rx_valid      FIFO head handshake
//   rx_data, parity_err, frame_err  head word and its status
//   overrun/overrun_clr    sticky dropped-word flag and its clear
//   fifo_count, busy       FIFO occupancy, FSM not idle
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          rx_clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    input  logic [15:0]                   baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic                          rx_ready,
    output logic                          rx_valid,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int unsigned OS_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam int unsigned SW     = DATA_BITS + 2;
    localparam int unsigned PAR_POS = status_par_pos(DATA_BITS);
    localparam int unsigned FRM_POS = status_frm_pos(DATA_BITS);
    localparam logic [OS_W-1:0] MID     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    // Synchroniser plus one extra stage for edge detection
    logic sync1_q, sync2_q, prev_q;
    logic fall_edge, start_edge;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    rx_state_e state_q, state_d;

    assign fall_edge  = prev_q & ~sync2_q;
    assign start_edge = (state_q == IDLE) & fall_edge;

    // Tick generator and per-bit oversample counter, both aligned to the start edge
    logic [15:0]     tick_cnt_q;
    logic [OS_W-1:0] os_cnt_q;
    logic            tick;

    assign tick = (tick_cnt_q == baud_div);

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
        end else if (start_edge) begin
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
            os_cnt_q   <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Bit decision point and value
    logic sample_now, bit_val;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Decision is taken at mid+1 using the two samples captured at mid-1 and mid
    logic [1:0] vote_q;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 2'b11;
        end else if (tick && (os_cnt_q == MID - 1'b1 || os_cnt_q == MID)) begin
            vote_q <= {vote_q[0], sync2_q};
        end
    end

    assign sample_now = tick & (os_cnt_q == MID + 1'b1);
    assign bit_val    = (vote_q[1] & vote_q[0]) | (vote_q[1] & sync2_q) | (vote_q[0] & sync2_q);
`else
    assign sample_now = tick & (os_cnt_q == MID);
    assign bit_val    = sync2_q;
`endif

    // Frame FSM and datapath
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [1:0]           cfg_parity_q, cfg_parity_d;
    logic                 cfg_two_stop_q, cfg_two_stop_d;
    logic                 cfg_parity_en;
    logic                 stop_fe;
    logic                 push;
    logic [SW-1:0]        push_word;

    assign cfg_parity_en = (cfg_parity_q == PARITY_EVEN) | (cfg_parity_q == PARITY_ODD);
    assign stop_fe       = frm_err_q | ~bit_val;
    assign push_word     = {stop_fe, par_err_q, shift_q};

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            par_err_q      <= 1'b0;
            frm_err_q      <= 1'b0;
            cfg_parity_q   <= PARITY_NONE;
            cfg_two_stop_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            par_err_q      <= par_err_d;
            frm_err_q      <= frm_err_d;
            cfg_parity_q   <= cfg_parity_d;
            cfg_two_stop_q <= cfg_two_stop_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        par_err_d      = par_err_q;
        frm_err_d      = frm_err_q;
        cfg_parity_d   = cfg_parity_q;
        cfg_two_stop_d = cfg_two_stop_q;
        push           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    state_d        = START;
                    cfg_parity_d   = parity_mode;
                    cfg_two_stop_d = two_stop;
                    par_err_d      = 1'b0;
                    frm_err_d      = 1'b0;
                    bit_cnt_d      = '0;
                end
            end
            START: begin
                if (sample_now) begin
                    // Line back high at mid-start: treat as a glitch
                    state_d   = bit_val ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_now) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = cfg_parity_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_now) begin
                    par_err_d = (cfg_parity_q == PARITY_ODD) ? ~^{shift_q, bit_val}
                                                              : ^{shift_q, bit_val};
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample_now) begin
                    if (cfg_two_stop_q) begin
                        frm_err_d = stop_fe;
                        state_d   = STOP2;
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            STOP2: begin
                if (sample_now) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receive FIFO and sticky overrun
    logic [SW-1:0] head;
    logic          fifo_full, fifo_empty, pop;

    assign pop = rx_valid & rx_ready;

    uart_rx_fifo #(
        .WIDTH (SW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (rx_clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    logic overrun_q;

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun    = overrun_q;
    assign rx_valid   = ~fifo_empty;
    assign rx_data    = head[STATUS_DATA_LSB +: DATA_BITS];
    assign parity_err = head[PAR_POS];
    assign frame_err  = head[FRM_POS];
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised self-checking bench for uart_rx_os (baud_div=3, OVERSAMPLE=16 -> 64 clk/bit).
// A second instance with DATA_BITS=7 shares the serial line for the 7-bit frame case.
module tb_uart_rx_os;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned BIT_CLKS = 64;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } word_t;

    logic        rx_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        serial_in = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic        rx_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        rx_valid, parity_err, frame_err, overrun, busy;
    logic [7:0]  rx_data;
    logic [3:0]  fifo_count;

    logic        rx_ready7 = 1'b0;
    logic        overrun_clr7 = 1'b0;
    logic        rx_valid7, parity_err7, frame_err7, overrun7, busy7;
    logic [6:0]  rx_data7;
    logic [3:0]  fifo_count7;

    always #5 rx_clk = ~rx_clk;

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)) dut (
        .rx_clk      (rx_clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .rx_ready    (rx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .fifo_count  (fifo_count),
        .busy        (busy)
    );

    uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)) dut7 (
        .rx_clk      (rx_clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .rx_ready    (rx_ready7),
        .rx_valid    (rx_valid7),
        .rx_data     (rx_data7),
        .parity_err  (parity_err7),
        .frame_err   (frame_err7),
        .overrun     (overrun7),
        .overrun_clr (overrun_clr7),
        .fifo_count  (fifo_count7),
        .busy        (busy7)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    word_t exp_q[$];
    logic  model_overrun = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: a word's flags follow directly from how the frame was transmitted
    function automatic word_t model_word(input int nbits, input logic [8:0] data,
                                         input logic [1:0] pmode, input logic tstop,
                                         input logic flip, input logic s1, input logic s2);
        word_t w;
        w.data = data & ((9'h1 << nbits) - 9'h1);
        w.pe   = (pmode == 2'b01 || pmode == 2'b10) ? flip : 1'b0;
        w.fe   = ~s1 | (tstop & ~s2);
        return w;
    endfunction

    task automatic model_push(input word_t w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else model_overrun = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (BIT_CLKS) @(posedge rx_clk);
    endtask

    task automatic send_frame(input int nbits, input logic [8:0] data, input logic [1:0] pmode,
                              input logic tstop, input logic flip, input logic s1,
                              input logic s2);
        logic p;
        parity_mode = pmode;
        two_stop    = tstop;
        send_bit(1'b0);
        // Format inputs change mid-frame; the frame must still use the values at its start
        parity_mode = 2'($urandom);
        two_stop    = 1'($urandom);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            send_bit(data[i]);
            p ^= data[i];
        end
        if (pmode == 2'b01 || pmode == 2'b10) begin
            if (pmode == 2'b10) p = ~p;
            send_bit(p ^ flip);
        end
        send_bit(s1);
        if (tstop) send_bit(s2);
        send_bit(1'b1);
    endtask

    task automatic send_checked(input logic [7:0] data, input logic [1:0] pmode,
                                input logic tstop, input logic flip, input logic s1,
                                input logic s2);
        send_frame(8, {1'b0, data}, pmode, tstop, flip, s1, s2);
        model_push(model_word(8, {1'b0, data}, pmode, tstop, flip, s1, s2));
    endtask

    task automatic expect_head(input string tag);
        word_t w;
        int    waited;
        @(negedge rx_clk);
        waited = 0;
        while (!rx_valid && waited < 4 * BIT_CLKS) begin
            @(negedge rx_clk);
            waited++;
        end
        check_eq({tag, ".valid"}, {31'd0, rx_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check_eq({tag, ".data"}, {24'd0, rx_data}, {23'd0, w.data});
            check_eq({tag, ".flags"}, {30'd0, frame_err, parity_err}, {30'd0, w.fe, w.pe});
        end
        rx_ready = 1'b1;
        @(negedge rx_clk);
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge rx_clk);
        rst_n = 1'b0;
        repeat (5) @(negedge rx_clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_overrun = 1'b0;
        repeat (5) @(negedge rx_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w;
        int    waited;
        logic [7:0] d;
        logic [1:0] pm;
        logic       ts, fl, s1, s2;

        // Reset state
        repeat (3) @(negedge rx_clk);
        check_eq("rst.outs", {26'd0, rx_valid, parity_err, frame_err, overrun, busy, 1'b0},
                 32'd0);
        check_eq("rst.data", {24'd0, rx_data}, 32'd0);
        check_eq("rst.count", {28'd0, fifo_count}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge rx_clk);

        // 8N1 0xA5
        send_checked(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge rx_clk);
        check_eq("a5.count", {28'd0, fifo_count}, 32'd1);
        expect_head("a5");

        // 8E1 0x03 with parity bit 1 (wrong)
        send_checked(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_head("e1_03");

        // 8O2 0x41 correct parity
        send_checked(8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_head("o2_41");

        // 7O2 0x41 on the 7-bit instance
        do_reset();
        send_frame(7, 9'h041, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        w = model_word(7, 9'h041, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge rx_clk);
        check_eq("7o2.valid", {31'd0, rx_valid7}, 32'd1);
        check_eq("7o2.data", {25'd0, rx_data7}, {23'd0, w.data});
        check_eq("7o2.flags", {30'd0, frame_err7, parity_err7}, {30'd0, w.fe, w.pe});
        check_eq("7o2.count", {28'd0, fifo_count7}, 32'd1);
        do_reset();

        // Stop bit low on 0x55, then a clean frame
        send_checked(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_head("ferr_55");
        send_checked(8'h96, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_head("after_ferr");

        // 24-clock glitch on idle line
        @(negedge rx_clk);
        serial_in = 1'b0;
        repeat (10) @(negedge rx_clk);
        check_eq("glitch.busy_on", {31'd0, busy}, 32'd1);
        repeat (14) @(negedge rx_clk);
        serial_in = 1'b1;
        waited = 0;
        while (busy && waited < BIT_CLKS) begin
            @(negedge rx_clk);
            waited++;
        end
        check_eq("glitch.busy_off", {31'd0, busy}, 32'd0);
        check_eq("glitch.count", {28'd0, fifo_count}, 32'd0);
        repeat (BIT_CLKS) @(negedge rx_clk);
        check_eq("glitch.valid", {31'd0, rx_valid}, 32'd0);

        // Random frames with random format and injected errors
        for (int n = 0; n < 20; n++) begin
            d  = 8'($urandom);
            pm = 2'($urandom_range(0, 3));
            ts = 1'($urandom);
            fl = (pm == 2'b01 || pm == 2'b10) && ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 7) != 0);
            s2 = ($urandom_range(0, 7) != 0);
            send_checked(d, pm, ts, fl, s1, s2);
            expect_head($sformatf("rand%0d", n));
        end

        // Overflow: DEPTH+1 frames with no consumer
        for (int n = 0; n <= DEPTH; n++) begin
            send_checked(8'($urandom), 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1, 1'b1);
        end
        @(negedge rx_clk);
        check_eq("ovf.count", {28'd0, fifo_count}, DEPTH);
        check_eq("ovf.flag", {31'd0, overrun}, {31'd0, model_overrun});
        check_eq("ovf.head", {24'd0, rx_data}, {23'd0, exp_q[0].data});
        overrun_clr = 1'b1;
        @(negedge rx_clk);
        overrun_clr = 1'b0;
        check_eq("ovf.clr", {31'd0, overrun}, 32'd0);
        for (int n = 0; n < DEPTH; n++) expect_head($sformatf("drain%0d", n));
        check_eq("drain.count", {28'd0, fifo_count}, 32'd0);

        // Reset during DATA of the second frame
        send_checked(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (20) @(posedge rx_clk);
        @(negedge rx_clk);
        check_eq("midrst.busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst.outs", {27'd0, rx_valid, parity_err, frame_err, overrun, busy}, 32'd0);
        check_eq("midrst.count", {28'd0, fifo_count}, 32'd0);
        check_eq("midrst.data", {24'd0, rx_data}, 32'd0);
        exp_q.delete();
        serial_in = 1'b1;
        repeat (10) @(negedge rx_clk);
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(negedge rx_clk);
        check_eq("midrst.idle", {30'd0, busy, rx_valid}, 32'd0);
        send_checked(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge rx_clk);
        check_eq("3c.count", {28'd0, fifo_count}, 32'd1);
        expect_head("3c");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
